// File: rtl/mcu_bus_receiver.sv
// 8080-style MCU bus receiver: synchronises wr/dcx/D, decodes CASET/PASET/RAMWR, emits addressed RGB565 pixels.
// Optional frame counter enabled by defining MCU_RX_FRAMECNT_EN. COORD_W must be 9..16.
module mcu_bus_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int COORD_W     = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr,
  input  logic               dcx,
  input  logic [7:0]         D,
  output logic               cmd_valid,
  output logic [7:0]         cmd_code,
  output logic               pix_valid,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [15:0]        pix_data,
  output logic               err,
  output logic [15:0]        frame_cnt
);

  localparam int HI_W = COORD_W - 8;
  localparam logic [COORD_W-1:0] XE_RST = COORD_W'(239);
  localparam logic [COORD_W-1:0] YE_RST = COORD_W'(319);

  typedef enum logic [1:0] {IDLE, CASET, PASET, RAMWR} state_t;

  logic       wr_sync_q  [SYNC_STAGES];
  logic       dcx_sync_q [SYNC_STAGES];
  logic [7:0] d_sync_q   [SYNC_STAGES];

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            wr_sync_q[0]  <= 1'b0;
            dcx_sync_q[0] <= 1'b0;
            d_sync_q[0]   <= 8'h00;
          end else begin
            wr_sync_q[0]  <= wr;
            dcx_sync_q[0] <= dcx;
            d_sync_q[0]   <= D;
          end
        end
      end else begin : g_next
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            wr_sync_q[gi]  <= 1'b0;
            dcx_sync_q[gi] <= 1'b0;
            d_sync_q[gi]   <= 8'h00;
          end else begin
            wr_sync_q[gi]  <= wr_sync_q[gi-1];
            dcx_sync_q[gi] <= dcx_sync_q[gi-1];
            d_sync_q[gi]   <= d_sync_q[gi-1];
          end
        end
      end
    end
  endgenerate

  logic wr_s;
  logic wr_prev_q;
  logic wr_rise;
  assign wr_s    = wr_sync_q[SYNC_STAGES-1];
  assign wr_rise = wr_s & ~wr_prev_q;

  // Accepted byte register: the FSM works on this copy one cycle after edge detection.
  logic       acc_q;
  logic       dcx_q;
  logic [7:0] byte_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_prev_q <= 1'b0;
      acc_q     <= 1'b0;
      dcx_q     <= 1'b0;
      byte_q    <= 8'h00;
    end else begin
      wr_prev_q <= wr_s;
      acc_q     <= wr_rise;
      if (wr_rise) begin
        dcx_q  <= dcx_sync_q[SYNC_STAGES-1];
        byte_q <= d_sync_q[SYNC_STAGES-1];
      end
    end
  end

  state_t             state_q, state_d;
  logic [1:0]         pcnt_q, pcnt_d;
  logic [HI_W-1:0]    hi_q, hi_d;
  logic [COORD_W-1:0] start_q, start_d;
  logic [COORD_W-1:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               phase_q, phase_d;
  logic [7:0]         pix_hi_q, pix_hi_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic [7:0]         cmd_code_q, cmd_code_d;
  logic               pix_valid_q, pix_valid_d;
  logic [COORD_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [15:0]        pix_data_q, pix_data_d;
  logic               err_q, err_d;
  logic [COORD_W-1:0] end_raw;
  logic [COORD_W-1:0] end_v;

  assign end_raw = {hi_q, byte_q};
  assign end_v   = (end_raw < start_q) ? start_q : end_raw;

  always_comb begin
    state_d     = state_q;
    pcnt_d      = pcnt_q;
    hi_d        = hi_q;
    start_d     = start_q;
    xs_d        = xs_q;
    xe_d        = xe_q;
    ys_d        = ys_q;
    ye_d        = ye_q;
    x_d         = x_q;
    y_d         = y_q;
    phase_d     = phase_q;
    pix_hi_d    = pix_hi_q;
    cmd_valid_d = 1'b0;
    cmd_code_d  = cmd_code_q;
    pix_valid_d = 1'b0;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_data_d  = pix_data_q;
    err_d       = 1'b0;
    if (acc_q) begin
      if (!dcx_q) begin
        cmd_valid_d = 1'b1;
        cmd_code_d  = byte_q;
        pcnt_d      = 2'd0;
        phase_d     = 1'b0;
        // Leaving a parameter phase early or dropping an unpaired pixel byte is a protocol error.
        if (state_q == CASET || state_q == PASET || (state_q == RAMWR && phase_q))
          err_d = 1'b1;
        case (byte_q)
          8'h2A:   state_d = CASET;
          8'h2B:   state_d = PASET;
          8'h2C: begin
            state_d = RAMWR;
            x_d     = xs_q;
            y_d     = ys_q;
          end
          default: state_d = IDLE;
        endcase
      end else begin
        case (state_q)
          CASET, PASET: begin
            pcnt_d = pcnt_q + 2'd1;
            case (pcnt_q)
              2'd0: hi_d = byte_q[HI_W-1:0];
              2'd1: start_d = {hi_q, byte_q};
              2'd2: hi_d = byte_q[HI_W-1:0];
              default: begin
                state_d = IDLE;
                if (state_q == CASET) begin
                  xs_d = start_q;
                  xe_d = end_v;
                end else begin
                  ys_d = start_q;
                  ye_d = end_v;
                end
              end
            endcase
          end
          RAMWR: begin
            if (!phase_q) begin
              pix_hi_d = byte_q;
              phase_d  = 1'b1;
            end else begin
              phase_d     = 1'b0;
              pix_valid_d = 1'b1;
              pix_data_d  = {pix_hi_q, byte_q};
              pix_x_d     = x_q;
              pix_y_d     = y_q;
              if (x_q >= xe_q) begin
                x_d = xs_q;
                y_d = (y_q >= ye_q) ? ys_q : y_q + 1'b1;
              end else begin
                x_d = x_q + 1'b1;
              end
            end
          end
          default: err_d = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pcnt_q      <= 2'd0;
      hi_q        <= '0;
      start_q     <= '0;
      xs_q        <= '0;
      xe_q        <= XE_RST;
      ys_q        <= '0;
      ye_q        <= YE_RST;
      x_q         <= '0;
      y_q         <= '0;
      phase_q     <= 1'b0;
      pix_hi_q    <= 8'h00;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= 8'h00;
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_data_q  <= 16'h0000;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      hi_q        <= hi_d;
      start_q     <= start_d;
      xs_q        <= xs_d;
      xe_q        <= xe_d;
      ys_q        <= ys_d;
      ye_q        <= ye_d;
      x_q         <= x_d;
      y_q         <= y_d;
      phase_q     <= phase_d;
      pix_hi_q    <= pix_hi_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_data_q  <= pix_data_d;
      err_q       <= err_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;
  assign pix_valid = pix_valid_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_data  = pix_data_q;
  assign err       = err_q;

`ifdef MCU_RX_FRAMECNT_EN
  logic        frame_done;
  logic [15:0] frame_cnt_q;
  assign frame_done = acc_q & dcx_q & (state_q == RAMWR) & phase_q &
                      (x_q >= xe_q) & (y_q >= ye_q);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             frame_cnt_q <= 16'h0000;
    else if (frame_done) frame_cnt_q <= frame_cnt_q + 16'h0001;
  end
  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mcu_bus_receiver.sv
// Directed bench for mcu_bus_receiver: bus-level byte writes, pulse recorder, per-scenario checks.
module tb_mcu_bus_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr = 1'b0;
  logic        dcx = 1'b0;
  logic [7:0]  D = 8'h00;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic        pix_valid;
  logic [8:0]  pix_x;
  logic [8:0]  pix_y;
  logic [15:0] pix_data;
  logic        err;
  logic [15:0] frame_cnt;

`ifdef MCU_RX_FRAMECNT_EN
  localparam int FC_EN = 1;
`else
  localparam int FC_EN = 0;
`endif

  int total = 0;
  int bad = 0;

  mcu_bus_receiver dut (
    .clk(clk), .rst(rst), .wr(wr), .dcx(dcx), .D(D),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .err(err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Pulse recorder: only this block writes the counters and pixel log.
  int          ncmd = 0;
  int          npix = 0;
  int          nerr = 0;
  int          nlong = 0;
  logic        pix_prev = 1'b0;
  logic [8:0]  px_log [64];
  logic [8:0]  py_log [64];
  logic [15:0] pd_log [64];

  always @(negedge clk) begin
    pix_prev <= pix_valid;
    if (pix_valid && pix_prev) nlong <= nlong + 1;
    if (cmd_valid) ncmd <= ncmd + 1;
    if (err) nerr <= nerr + 1;
    if (pix_valid) begin
      if (npix < 64) begin
        px_log[npix] <= pix_x;
        py_log[npix] <= pix_y;
        pd_log[npix] <= pix_data;
      end
      npix <= npix + 1;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wr  = 1'b0;
    dcx = 1'b0;
    D   = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send(input logic dc, input logic [7:0] b);
    @(negedge clk);
    dcx = dc;
    D   = b;
    wr  = 1'b0;
    repeat (2) @(negedge clk);
    wr = 1'b1;
    repeat (3) @(negedge clk);
    wr = 1'b0;
    repeat (6) @(negedge clk);
    $display("tx dcx=%0d byte=%02h ncmd=%0d npix=%0d nerr=%0d", dc, b, ncmd, npix, nerr);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (cmd_code !== 8'h00) begin bad++; $display("FAIL reset_cmd_code got=%02h want=00", cmd_code); end
    total++; if ({cmd_valid, pix_valid, err} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%03b want=000", {cmd_valid, pix_valid, err}); end
    total++; if ({pix_x, pix_y} !== 18'd0) begin bad++; $display("FAIL reset_xy got=%0d,%0d want=0,0", pix_x, pix_y); end
    total++; if (pix_data !== 16'h0000) begin bad++; $display("FAIL reset_pix_data got=%04h want=0000", pix_data); end
    total++; if (frame_cnt !== 16'h0000) begin bad++; $display("FAIL reset_frame_cnt got=%0d want=0", frame_cnt); end
  endtask

  task automatic test_first_pixel();
    int bc, bp, be;
    do_reset();
    bc = ncmd; bp = npix; be = nerr;
    send(1'b0, 8'h2C);
    send(1'b1, 8'hF8);
    send(1'b1, 8'h00);
    total++; if (npix - bp !== 1) begin bad++; $display("FAIL first_pix_count got=%0d want=1", npix - bp); end
    total++; if ({px_log[bp], py_log[bp]} !== {9'd0, 9'd0}) begin bad++; $display("FAIL first_pix_xy got=%0d,%0d want=0,0", px_log[bp], py_log[bp]); end
    total++; if (pd_log[bp] !== 16'hF800) begin bad++; $display("FAIL first_pix_data got=%04h want=F800", pd_log[bp]); end
    total++; if (ncmd - bc !== 1) begin bad++; $display("FAIL first_cmd_count got=%0d want=1", ncmd - bc); end
    total++; if (cmd_code !== 8'h2C) begin bad++; $display("FAIL first_cmd_code got=%02h want=2C", cmd_code); end
    total++; if (nerr - be !== 0) begin bad++; $display("FAIL first_err got=%0d want=0", nerr - be); end
  endtask

  task automatic test_window();
    int bp, be;
    logic [8:0]  ex [5] = '{9'd5, 9'd6, 9'd5, 9'd6, 9'd5};
    logic [8:0]  ey [5] = '{9'd10, 9'd10, 9'd11, 9'd11, 9'd10};
    logic [15:0] ed [5] = '{16'h1122, 16'h3344, 16'h5566, 16'h7788, 16'h99AA};
    logic [7:0]  caset [4] = '{8'h00, 8'h05, 8'h00, 8'h06};
    logic [7:0]  paset [4] = '{8'h00, 8'h0A, 8'h00, 8'h0B};
    logic [7:0]  pix [10] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
    do_reset();
    bp = npix; be = nerr;
    send(1'b0, 8'h2A);
    for (int i = 0; i < 4; i++) send(1'b1, caset[i]);
    send(1'b0, 8'h2B);
    for (int i = 0; i < 4; i++) send(1'b1, paset[i]);
    send(1'b0, 8'h2C);
    for (int i = 0; i < 8; i++) send(1'b1, pix[i]);
    total++; if (frame_cnt !== 16'(FC_EN)) begin bad++; $display("FAIL win_frame_cnt got=%0d want=%0d", frame_cnt, FC_EN); end
    for (int i = 8; i < 10; i++) send(1'b1, pix[i]);
    total++; if (npix - bp !== 5) begin bad++; $display("FAIL win_pix_count got=%0d want=5", npix - bp); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({px_log[bp+i], py_log[bp+i], pd_log[bp+i]} !== {ex[i], ey[i], ed[i]}) begin
        bad++;
        $display("FAIL win_pix%0d got=(%0d,%0d,%04h) want=(%0d,%0d,%04h)", i,
                 px_log[bp+i], py_log[bp+i], pd_log[bp+i], ex[i], ey[i], ed[i]);
      end
    end
    total++; if (nerr - be !== 0) begin bad++; $display("FAIL win_err got=%0d want=0", nerr - be); end
  endtask

  task automatic test_end_below_start();
    int bp;
    logic [7:0] caset [4] = '{8'h00, 8'h08, 8'h00, 8'h03};
    logic [7:0] paset [4] = '{8'h00, 8'h02, 8'h00, 8'h02};
    do_reset();
    bp = npix;
    send(1'b0, 8'h2A);
    for (int i = 0; i < 4; i++) send(1'b1, caset[i]);
    send(1'b0, 8'h2B);
    for (int i = 0; i < 4; i++) send(1'b1, paset[i]);
    send(1'b0, 8'h2C);
    send(1'b1, 8'h01); send(1'b1, 8'h02);
    send(1'b1, 8'h03); send(1'b1, 8'h04);
    total++; if (npix - bp !== 2) begin bad++; $display("FAIL clamp_pix_count got=%0d want=2", npix - bp); end
    total++; if ({px_log[bp], py_log[bp]} !== {9'd8, 9'd2}) begin bad++; $display("FAIL clamp_pix0 got=%0d,%0d want=8,2", px_log[bp], py_log[bp]); end
    total++; if ({px_log[bp+1], py_log[bp+1], pd_log[bp+1]} !== {9'd8, 9'd2, 16'h0304}) begin bad++; $display("FAIL clamp_pix1 got=%0d,%0d,%04h want=8,2,0304", px_log[bp+1], py_log[bp+1], pd_log[bp+1]); end
    total++; if (frame_cnt !== 16'(2 * FC_EN)) begin bad++; $display("FAIL clamp_frame_cnt got=%0d want=%0d", frame_cnt, 2 * FC_EN); end
  endtask

  task automatic test_partial_param();
    int bp, be;
    do_reset();
    bp = npix; be = nerr;
    send(1'b0, 8'h2A);
    send(1'b1, 8'h00);
    send(1'b1, 8'h05);
    send(1'b0, 8'h2C);
    total++; if (nerr - be !== 1) begin bad++; $display("FAIL partial_err got=%0d want=1", nerr - be); end
    send(1'b1, 8'h01);
    send(1'b1, 8'h02);
    send(1'b1, 8'h03);
    send(1'b1, 8'h04);
    total++; if (npix - bp !== 2) begin bad++; $display("FAIL partial_pix_count got=%0d want=2", npix - bp); end
    total++; if ({px_log[bp], py_log[bp], pd_log[bp]} !== {9'd0, 9'd0, 16'h0102}) begin bad++; $display("FAIL partial_pix0 got=%0d,%0d,%04h want=0,0,0102", px_log[bp], py_log[bp], pd_log[bp]); end
    total++; if ({px_log[bp+1], py_log[bp+1]} !== {9'd1, 9'd0}) begin bad++; $display("FAIL partial_pix1 got=%0d,%0d want=1,0", px_log[bp+1], py_log[bp+1]); end
  endtask

  task automatic test_unpaired();
    int bp, be;
    do_reset();
    bp = npix; be = nerr;
    send(1'b0, 8'h2C);
    send(1'b1, 8'h12);
    send(1'b0, 8'h2C);
    send(1'b1, 8'h34);
    send(1'b1, 8'h56);
    total++; if (nerr - be !== 1) begin bad++; $display("FAIL unpaired_err got=%0d want=1", nerr - be); end
    total++; if (npix - bp !== 1) begin bad++; $display("FAIL unpaired_pix_count got=%0d want=1", npix - bp); end
    total++; if ({px_log[bp], py_log[bp], pd_log[bp]} !== {9'd0, 9'd0, 16'h3456}) begin bad++; $display("FAIL unpaired_pix got=%0d,%0d,%04h want=0,0,3456", px_log[bp], py_log[bp], pd_log[bp]); end
  endtask

  task automatic test_idle_data();
    int bc, bp, be;
    do_reset();
    bc = ncmd; bp = npix; be = nerr;
    send(1'b1, 8'hAA);
    total++; if (nerr - be !== 1) begin bad++; $display("FAIL idle_err got=%0d want=1", nerr - be); end
    total++; if (npix - bp !== 0) begin bad++; $display("FAIL idle_pix got=%0d want=0", npix - bp); end
    total++; if (ncmd - bc !== 0) begin bad++; $display("FAIL idle_cmd got=%0d want=0", ncmd - bc); end
  endtask

  task automatic test_reset_mid();
    int bp, be;
    do_reset();
    send(1'b0, 8'h2C);
    send(1'b1, 8'hAB);
    do_reset();
    bp = npix; be = nerr;
    send(1'b0, 8'h2C);
    send(1'b1, 8'hAB);
    send(1'b1, 8'hCD);
    total++; if (nerr - be !== 0) begin bad++; $display("FAIL midrst_err got=%0d want=0", nerr - be); end
    total++; if (npix - bp !== 1) begin bad++; $display("FAIL midrst_pix_count got=%0d want=1", npix - bp); end
    total++; if ({px_log[bp], py_log[bp], pd_log[bp]} !== {9'd0, 9'd0, 16'hABCD}) begin bad++; $display("FAIL midrst_pix got=%0d,%0d,%04h want=0,0,ABCD", px_log[bp], py_log[bp], pd_log[bp]); end
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_window();
    test_end_below_start();
    test_partial_param();
    test_unpaired();
    test_idle_data();
    test_reset_mid();
    total++; if (nlong !== 0) begin bad++; $display("FAIL pix_pulse_width got=%0d long pulses want=0", nlong); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mcu_bus_receiver.md
MCU_BUS_RECEIVER -- requirements
Module: mcu_bus_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth on all bus inputs.
REQ-002 SHALL have parameter COORD_W, default 9: width of column/page coordinates.
REQ-003 SHALL have clk  input  1  single clock for all logic.
REQ-004 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have wr  input  1  write strobe from 8-bit 8080-style MCU bus; byte latched on rising edge.
REQ-006 SHALL have dcx  input  1  0 = command byte, 1 = data/parameter byte.
REQ-007 SHALL have D  input  8  bus data byte.
REQ-008 SHALL have cmd_valid  output  1  one-cycle pulse per accepted command byte.
REQ-009 SHALL have cmd_code  output  8  last command byte; held until the next command.
REQ-010 SHALL have pix_valid  output  1  one-cycle pulse per assembled pixel.
REQ-011 SHALL have pix_x, pix_y  output  COORD_W each  pixel address for the current pix_valid.
REQ-012 SHALL have pix_data  output  16  RGB565 pixel; first byte is bits 15:8.
REQ-013 SHALL have err  output  1  one-cycle pulse on a protocol violation.
REQ-014 SHALL have frame_cnt  output  16  completed-window count (see Configuration).

Function
REQ-015 SHALL pass wr, dcx and D through SYNC_STAGES flops and detect the wr rising edge on the synchronised copy; a byte is accepted one cycle after detection (SYNC_STAGES+1 clk after the pin edge).
REQ-016 SHALL use FSM states IDLE, CASET, PASET, RAMWR; each byte accepted with dcx=0 is a command and always pulses cmd_valid, updates cmd_code and re-dispatches the FSM regardless of current state.
REQ-017 Command 0x2A SHALL enter CASET; 0x2B PASET; 0x2C RAMWR with x:=xs, y:=ys and the pixel byte phase cleared; any other command enters IDLE.
REQ-018 CASET/PASET SHALL take exactly 4 data bytes (start MSB, start LSB, end MSB, end LSB), truncated to COORD_W, then return to IDLE; the new window takes effect only after the 4th byte.
REQ-019 If the loaded end < start, end SHALL be stored equal to start.
REQ-020 A command arriving before all 4 parameters SHALL abandon the partial update (old window kept) and pulse err.
REQ-021 In RAMWR, data bytes SHALL pair into one pixel; pix_valid, pix_x, pix_y and pix_data update one cycle after the second byte is accepted.
REQ-022 After each pixel, x SHALL increment; at x=xe, x wraps to xs and y increments; at x=xe and y=ye, both wrap to xs/ys (frame complete).
REQ-023 A command arriving with one unpaired pixel byte SHALL discard that byte and pulse err.
REQ-024 A data byte accepted in IDLE SHALL be ignored and pulse err.
REQ-025 Pixel and error pulses SHALL never be longer than one cycle; at most one byte is accepted per wr edge.

Reset
REQ-026 On rst: FSM=IDLE, synchroniser flops=0, cmd_valid=pix_valid=err=0, cmd_code=0x00, pix_x=pix_y=0, pix_data=0, frame_cnt=0, window xs=0, xe=239, ys=0, ye=319.
REQ-027 Reset asserted mid-transfer SHALL discard all partial parameters and pixel bytes; no pulses occur while rst is high or in the first cycle after release.

Configuration
REQ-028 With MCU_RX_FRAMECNT_EN defined, frame_cnt SHALL increment (wrapping at 0xFFFF) on each frame completion per REQ-022; without it, frame_cnt SHALL be constant 0 and the counter is not synthesised.

Verification
REQ-029 After reset, send cmd 0x2C then bytes 0xF8,0x00 -> one pix_valid with pix_x=0, pix_y=0, pix_data=0xF800; cmd_valid pulsed once with cmd_code=0x2C.
REQ-030 CASET 0x00,0x05,0x00,0x06; PASET 0x00,0x0A,0x00,0x0B; RAMWR + 8 bytes -> pixels at (5,10),(6,10),(5,11),(6,11); frame_cnt=1 when the macro is defined, else 0.
REQ-031 CASET 0x00,0x05 then cmd 0x2C -> err pulse; window stays 0..239; first pixel at (0,0).
REQ-032 RAMWR, one byte 0x12, then cmd 0x2C, then 0x34,0x56 -> err pulse; single pixel 0x3456 at (0,0).
REQ-033 Data byte 0xAA right after reset -> err pulse, no pix_valid, no cmd_valid.
REQ-034 Assert rst after first byte of a pixel, release, send RAMWR + 0xAB,0xCD -> pixel 0xABCD at (0,0), no err.
